lcd_init_ctrl: RTL and testbench
================================

Name: lcd_init_ctrl

Overview:
Power-up sequencer for the RGB LCD panel interface.
- Holds the RGB bus tristated while the panel's strap pins settle.
- Samples the M2/M1/M0 straps (B7, G7, R7) several times and checks that all samples agree.
- Decodes the panel ID and publishes the matching resolution and pixel-clock divider.
- Releases panel reset, enables the RGB drivers, then turns on the backlight after a delay.
- Sits between the raw pad interface and the LCD timing generator and clock divider.

Parameters:
- SETTLE_CYC, 1000: cycles the bus is held tristated before sampling.
- SAMPLE_NUM, 4: number of consecutive strap samples that must match (≥2).
- RETRY_MAX, 3: mismatched sampling rounds allowed before falling back.
- BL_DELAY_CYC, 5000: cycles from driver enable to backlight on.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- lcd_rgb_in, input, 24: RGB pad input value; strap bits are [7], [15], [23].
- lcd_rgb_oe, output, 1: RGB pad output enable; 0 = tristate.
- lcd_rst_n, output, 1: panel reset, active low.
- lcd_bl, output, 1: backlight enable.
- lcd_id, output, 16: decoded panel ID.
- h_disp, output, 11: active pixels per line.
- v_disp, output, 11: active lines per frame.
- clk_div_sel, output, 2: pixel clock select. 0 = /1, 1 = /2, 2 = /4.
- id_valid, output, 1: lcd_id, h_disp, v_disp and clk_div_sel are stable.
- init_done, output, 1: sequence complete, timing generator may run.
- id_err, output, 1: fallback timing in use.

Behaviour:
- Reset values: all outputs 0 (lcd_rst_n=0, lcd_bl=0, lcd_rgb_oe=0, lcd_id=0, h_disp=0, v_disp=0, clk_div_sel=0, id_valid=0, init_done=0, id_err=0). State = SETTLE, retry count = 0.
- Reset asserted mid-sequence: all outputs return to reset values immediately and the sequence restarts from SETTLE when reset is released.
- States: SETTLE → SAMPLE → DECODE → PWR → RUN.
- SETTLE: lcd_rgb_oe=0 for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: capture code = {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]} on SAMPLE_NUM consecutive cycles.
  - All samples equal: go to DECODE.
  - Any sample differs: increment retry count and return to SETTLE.
  - Mismatch when retry count = RETRY_MAX: go to DECODE with the fallback flag set.
- DECODE: one cycle; registers all outputs. Code → lcd_id, h_disp x v_disp, clk_div_sel:
  - 000 → 4342, 480x272, 2
  - 001 → 7084, 800x480, 1
  - 010 → 7016, 1024x600, 0
  - 100 → 4384, 800x480, 1
  - 101 → 1018, 1280x800, 0
  - Other codes, or fallback flag set → lcd_id=0, 480x272, clk_div_sel=2, id_err=1.
- DECODE exit: id_valid=1 and lcd_rst_n=1 on the first PWR cycle.
- PWR:
  - lcd_rgb_oe=1 from the second PWR cycle onward.
  - After a further BL_DELAY_CYC cycles: lcd_bl=1 and init_done=1, same edge; go to RUN.
- RUN: terminal. All outputs are frozen until reset.
- id_valid, lcd_id, h_disp, v_disp and clk_div_sel never change while id_valid=1.
- Counters are sized by $clog2 of their parameter and saturate; no wrap.

Optional Feature:
- Macro LCD_ID_OVERRIDE_EN.
- Defined: adds input force_en (1 bit) and input force_code (3 bits).
  - If force_en=1 on SETTLE exit, SAMPLE is skipped and force_code is decoded directly.
  - id_err follows the normal decode rule.
- Undefined: the ports are absent and straps are always sampled.

Decomposition:
- Package lcd_pkg holds:
  - state enum;
  - ID constants (ID_4342, ID_7084, ID_7016, ID_4384, ID_1018);
  - per-ID resolution and divider constants;
  - fallback constants.
- One sub-module, lcd_timing_lut: combinational map from 3-bit code to {lcd_id, h_disp, v_disp, clk_div_sel, unknown}.

Test Plan:
- Straps hold code 001 steadily → id_valid rises at cycle SETTLE_CYC+SAMPLE_NUM+1 with lcd_id=7084, h_disp=800, v_disp=480, clk_div_sel=1. lcd_bl and init_done rise BL_DELAY_CYC+1 cycles later. id_err=0.
- Code 011 held steadily → lcd_id=0, 480x272, clk_div_sel=2, id_err=1, init_done still asserts.
- Strap bit toggles every cycle → 4 sampling rounds (RETRY_MAX+1) are observed, then fallback with id_err=1. lcd_rgb_oe stays 0 in every SETTLE.
- One glitch in the first round, code 101 stable afterwards → lcd_id=1018, 1280x800, id_err=0, one extra SETTLE period.
- rst_n pulsed low during PWR → outputs return to reset values asynchronously. After release the full sequence repeats and re-decodes the new strap value.
- With LCD_ID_OVERRIDE_EN, force_en=1 and force_code=010, straps at 000 → lcd_id=7016, clk_div_sel=0, no SAMPLE cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: sequencer states and per-panel timing constants for lcd_init_ctrl.
package lcd_pkg;

   typedef enum logic [2:0] {SETTLE, SAMPLE, DECODE, PWR, RUN} state_t;

   typedef struct packed {
      logic [15:0] id;
      logic [10:0] h;
      logic [10:0] v;
      logic [1:0]  div;
      logic        unknown;
   } timing_t;

   localparam logic [15:0] ID_4342 = 16'h4342;
   localparam logic [15:0] ID_7084 = 16'h7084;
   localparam logic [15:0] ID_7016 = 16'h7016;
   localparam logic [15:0] ID_4384 = 16'h4384;
   localparam logic [15:0] ID_1018 = 16'h1018;

   localparam logic [10:0] H_4342 = 11'd480;
   localparam logic [10:0] V_4342 = 11'd272;
   localparam logic [1:0]  DIV_4342 = 2'd2;
   localparam logic [10:0] H_7084 = 11'd800;
   localparam logic [10:0] V_7084 = 11'd480;
   localparam logic [1:0]  DIV_7084 = 2'd1;
   localparam logic [10:0] H_7016 = 11'd1024;
   localparam logic [10:0] V_7016 = 11'd600;
   localparam logic [1:0]  DIV_7016 = 2'd0;
   localparam logic [10:0] H_4384 = 11'd800;
   localparam logic [10:0] V_4384 = 11'd480;
   localparam logic [1:0]  DIV_4384 = 2'd1;
   localparam logic [10:0] H_1018 = 11'd1280;
   localparam logic [10:0] V_1018 = 11'd800;
   localparam logic [1:0]  DIV_1018 = 2'd0;

   localparam logic [15:0] FB_ID  = 16'h0000;
   localparam logic [10:0] FB_H   = 11'd480;
   localparam logic [10:0] FB_V   = 11'd272;
   localparam logic [1:0]  FB_DIV = 2'd2;

   localparam timing_t FB_TIMING = '{id: FB_ID, h: FB_H, v: FB_V, div: FB_DIV, unknown: 1'b1};

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lcd_timing_lut.sv
// lcd_timing_lut: maps the 3-bit strap code to panel ID, resolution and pixel-clock divider.
module lcd_timing_lut
   import lcd_pkg::*;
(
   input  logic [2:0] code,
   output timing_t    timing
);

   always_comb begin
      timing = FB_TIMING;
      case (code)
         3'b000: timing = '{ID_4342, H_4342, V_4342, DIV_4342, 1'b0};
         3'b001: timing = '{ID_7084, H_7084, V_7084, DIV_7084, 1'b0};
         3'b010: timing = '{ID_7016, H_7016, V_7016, DIV_7016, 1'b0};
         3'b100: timing = '{ID_4384, H_4384, V_4384, DIV_4384, 1'b0};
         3'b101: timing = '{ID_1018, H_1018, V_1018, DIV_1018, 1'b0};
         default: ;
      endcase
   end

endmodule

// File: rtl/lcd_init_ctrl.sv
// lcd_init_ctrl: RGB LCD power-up sequencer (strap sampling, ID decode, reset/driver/backlight); LCD_ID_OVERRIDE_EN adds force_en/force_code.
module lcd_init_ctrl
   import lcd_pkg::*;
#(
   parameter int SETTLE_CYC   = 1000,
   parameter int SAMPLE_NUM   = 4,
   parameter int RETRY_MAX    = 3,
   parameter int BL_DELAY_CYC = 5000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] lcd_rgb_in,
`ifdef LCD_ID_OVERRIDE_EN
   input  logic        force_en,
   input  logic [2:0]  force_code,
`endif
   output logic        lcd_rgb_oe,
   output logic        lcd_rst_n,
   output logic        lcd_bl,
   output logic [15:0] lcd_id,
   output logic [10:0] h_disp,
   output logic [10:0] v_disp,
   output logic [1:0]  clk_div_sel,
   output logic        id_valid,
   output logic        init_done,
   output logic        id_err
);

   localparam int SW = cnt_w(SETTLE_CYC);
   localparam int NW = cnt_w(SAMPLE_NUM);
   localparam int RW = cnt_w(RETRY_MAX + 1);
   localparam int BW = cnt_w(BL_DELAY_CYC + 1);

   state_t        state;
   logic [SW-1:0] settle_cnt;
   logic [NW-1:0] sample_cnt;
   logic [RW-1:0] retry_cnt;
   logic [BW-1:0] bl_cnt;
   logic [2:0]    code_q;
   logic [2:0]    strap;
   logic          mis_q;
   logic          mis_now;
   logic          fallback;
   logic          unused_pads;
   timing_t       lut;
   timing_t       dec;

   assign strap   = {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]};
   assign mis_now = mis_q | ((sample_cnt != '0) && (strap != code_q));
   assign dec     = fallback ? FB_TIMING : lut;
   // only the three strap bits matter during power-up
   assign unused_pads = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

   lcd_timing_lut u_lut (
      .code   (code_q),
      .timing (lut)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SETTLE;
         settle_cnt  <= '0;
         sample_cnt  <= '0;
         retry_cnt   <= '0;
         bl_cnt      <= '0;
         code_q      <= '0;
         mis_q       <= 1'b0;
         fallback    <= 1'b0;
         lcd_rgb_oe  <= 1'b0;
         lcd_rst_n   <= 1'b0;
         lcd_bl      <= 1'b0;
         lcd_id      <= '0;
         h_disp      <= '0;
         v_disp      <= '0;
         clk_div_sel <= '0;
         id_valid    <= 1'b0;
         init_done   <= 1'b0;
         id_err      <= 1'b0;
      end else begin
         case (state)
            SETTLE: begin
               if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                  settle_cnt <= '0;
                  sample_cnt <= '0;
                  mis_q      <= 1'b0;
                  state      <= SAMPLE;
`ifdef LCD_ID_OVERRIDE_EN
                  if (force_en) begin
                     code_q <= force_code;
                     state  <= DECODE;
                  end
`endif
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (sample_cnt == '0) code_q <= strap;
               mis_q <= mis_now;
               if (sample_cnt == NW'(SAMPLE_NUM - 1)) begin
                  if (!mis_now) begin
                     state <= DECODE;
                  end else if (retry_cnt == RW'(RETRY_MAX)) begin
                     fallback <= 1'b1;
                     state    <= DECODE;
                  end else begin
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= SETTLE;
                  end
               end else begin
                  sample_cnt <= sample_cnt + 1'b1;
               end
            end
            DECODE: begin
               lcd_id      <= dec.id;
               h_disp      <= dec.h;
               v_disp      <= dec.v;
               clk_div_sel <= dec.div;
               id_err      <= dec.unknown;
               id_valid    <= 1'b1;
               lcd_rst_n   <= 1'b1;
               bl_cnt      <= '0;
               state       <= PWR;
            end
            PWR: begin
               lcd_rgb_oe <= 1'b1;
               if (bl_cnt == BW'(BL_DELAY_CYC)) begin
                  lcd_bl    <= 1'b1;
                  init_done <= 1'b1;
                  state     <= RUN;
               end else begin
                  bl_cnt <= bl_cnt + 1'b1;
               end
            end
            RUN: ;
            default: state <= SETTLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// tb_lcd_init_ctrl: randomized strap streams checked against a round-based model of the power-up sequence.
module tb_lcd_init_ctrl;

   localparam int S = 20, N = 4, R = 3, B = 30;
   localparam int LIMIT = (R + 1) * (S + N) + B + 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] lcd_rgb_in = '0;
   logic        lcd_rgb_oe, lcd_rst_n, lcd_bl, id_valid, init_done, id_err;
   logic [15:0] lcd_id;
   logic [10:0] h_disp, v_disp;
   logic [1:0]  clk_div_sel;
`ifdef LCD_ID_OVERRIDE_EN
   logic        force_en = 1'b0;
   logic [2:0]  force_code = '0;
`endif

   logic [2:0] stream [256];
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   lcd_init_ctrl #(.SETTLE_CYC(S), .SAMPLE_NUM(N), .RETRY_MAX(R), .BL_DELAY_CYC(B)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lcd_rgb_in  (lcd_rgb_in),
`ifdef LCD_ID_OVERRIDE_EN
      .force_en    (force_en),
      .force_code  (force_code),
`endif
      .lcd_rgb_oe  (lcd_rgb_oe),
      .lcd_rst_n   (lcd_rst_n),
      .lcd_bl      (lcd_bl),
      .lcd_id      (lcd_id),
      .h_disp      (h_disp),
      .v_disp      (v_disp),
      .clk_div_sel (clk_div_sel),
      .id_valid    (id_valid),
      .init_done   (init_done),
      .id_err      (id_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] enc(input logic [2:0] c);
      logic [23:0] v;
      v = $urandom;
      v[7]  = c[2];
      v[15] = c[1];
      v[23] = c[0];
      return v;
   endfunction

   // Walks sampling rounds: S settle cycles then N samples; gives the edge where id_valid appears.
   task automatic model(output int v_edge, output logic [2:0] m_code, output logic m_fb);
      int t = 0;
      bit done = 0, eq;
      bit frc = 0;
      logic [2:0] fc = '0;
`ifdef LCD_ID_OVERRIDE_EN
      frc = force_en;
      fc  = force_code;
`endif
      m_fb = 1'b0;
      m_code = '0;
      for (int r = 0; r <= R && !done; r++) begin
         t += S;
         if (frc) begin
            m_code = fc;
            done = 1;
         end else begin
            eq = 1;
            for (int i = 1; i < N; i++) if (stream[t + i] != stream[t]) eq = 0;
            m_code = stream[t];
            t += N;
            if (eq) done = 1;
            else if (r == R) begin
               m_fb = 1'b1;
               done = 1;
            end
         end
      end
      v_edge = t + 1;
   endtask

   task automatic expect_panel(input logic [2:0] c, input logic fb,
                               output int id, output int h, output int v, output int d, output int err);
      case ({fb, c})
         4'b0000: begin id = 'h4342; h = 480;  v = 272; d = 2; err = 0; end
         4'b0001: begin id = 'h7084; h = 800;  v = 480; d = 1; err = 0; end
         4'b0010: begin id = 'h7016; h = 1024; v = 600; d = 0; err = 0; end
         4'b0100: begin id = 'h4384; h = 800;  v = 480; d = 1; err = 0; end
         4'b0101: begin id = 'h1018; h = 1280; v = 800; d = 0; err = 0; end
         default: begin id = 0;      h = 480;  v = 272; d = 2; err = 1; end
      endcase
   endtask

   task automatic run_seq(input string name);
      int v_exp, e, id, h, v, d, err;
      int v_edge = -1, rn_edge = -1, oe_edge = -1, bl_edge = -1, dn_edge = -1, chg = 0;
      logic [2:0] c;
      logic fb;
      logic [39:0] snap = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check({name, ":reset"}, {lcd_rgb_oe, lcd_rst_n, lcd_bl, lcd_id, h_disp, v_disp,
                               clk_div_sel, id_valid, init_done, id_err}, 0);
      model(v_exp, c, fb);
      expect_panel(c, fb, id, h, v, d, err);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < LIMIT; k++) begin
         lcd_rgb_in = enc(stream[k]);
         @(posedge clk);
         #1;
         e = k + 1;
         if (v_edge >= 0 && (!id_valid || {lcd_id, h_disp, v_disp, clk_div_sel} != snap)) chg++;
         if (id_valid && v_edge < 0) begin
            v_edge = e;
            snap = {lcd_id, h_disp, v_disp, clk_div_sel};
         end
         if (lcd_rst_n && rn_edge < 0) rn_edge = e;
         if (lcd_rgb_oe && oe_edge < 0) oe_edge = e;
         if (lcd_bl && bl_edge < 0) bl_edge = e;
         if (init_done && dn_edge < 0) dn_edge = e;
         @(negedge clk);
      end
      check({name, ":id_valid_edge"}, v_edge, v_exp);
      check({name, ":lcd_rst_n_edge"}, rn_edge, v_exp);
      check({name, ":oe_edge"}, oe_edge, v_exp + 1);
      check({name, ":bl_edge"}, bl_edge, v_exp + B + 1);
      check({name, ":init_done_edge"}, dn_edge, v_exp + B + 1);
      check({name, ":lcd_id"}, lcd_id, id);
      check({name, ":h_disp"}, h_disp, h);
      check({name, ":v_disp"}, v_disp, v);
      check({name, ":clk_div_sel"}, clk_div_sel, d);
      check({name, ":id_err"}, id_err, err);
      check({name, ":id_stable"}, chg, 0);
      check({name, ":run_outputs"}, {lcd_bl, init_done, lcd_rgb_oe, id_valid, lcd_rst_n}, 5'b11111);
   endtask

   task automatic fill_steady(input logic [2:0] c);
      for (int i = 0; i < 256; i++) stream[i] = c;
   endtask

   task automatic mid_reset();
      int v_exp;
      logic [2:0] c;
      logic fb;
      fill_steady(3'($urandom_range(7)));
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      model(v_exp, c, fb);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < v_exp + 5; k++) begin
         lcd_rgb_in = enc(stream[k]);
         @(posedge clk);
         @(negedge clk);
      end
      check("mid:pwr_reached", {id_valid, lcd_rst_n, lcd_rgb_oe, lcd_bl}, 4'b1110);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid:async_reset", {lcd_rgb_oe, lcd_rst_n, lcd_bl, lcd_id, h_disp, v_disp,
                                clk_div_sel, id_valid, init_done, id_err}, 0);
   endtask

   initial begin
      logic [2:0] base;
      repeat (3) @(posedge clk);
      fill_steady(3'b001);
      run_seq("code001");
      fill_steady(3'b011);
      run_seq("code011");
      for (int i = 0; i < 256; i++) stream[i] = (i % 2 == 1) ? 3'b001 : 3'b000;
      run_seq("toggle");
      fill_steady(3'b101);
      stream[S + 1] = 3'b100;
      run_seq("glitch101");
      for (int n = 0; n < 6; n++) begin
         base = 3'($urandom_range(7));
         for (int i = 0; i < 256; i++)
            stream[i] = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : base;
         run_seq("random");
      end
      mid_reset();
      fill_steady(3'($urandom_range(7)));
      run_seq("after_reset");
`ifdef LCD_ID_OVERRIDE_EN
      force_en = 1'b1;
      force_code = 3'b010;
      fill_steady(3'b000);
      run_seq("force010");
      force_en = 1'b0;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
